// File: rtl/riscv_uop_pkg.sv
// Shared micro-op types for the issue/writeback path: completion request record and
// architectural register helpers.
package riscv_uop_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Bit positions inside the writeback grant vector.
  localparam int GNT_ALU = 0;
  localparam int GNT_LSU = 1;

  typedef struct packed {
    logic        valid;
    logic        writes_rd;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  // A write to x0 is architecturally a no-op, so it never competes for the port.
  function automatic logic wb_wants_port(wb_req_t req);
    return req.valid && req.writes_rd && (req.rd != REG_X0);
  endfunction

endpackage

// File: rtl/wb_prio_picker.sv
// Combinational LSU-first picker for the ARF write port; the streak-limit flag hands
// one grant to a waiting ALU.
module wb_prio_picker
  import riscv_uop_pkg::*;
(
  input  logic       i_alu_want,
  input  logic       i_lsu_want,
  input  logic       i_streak_max,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_lsu_want && !(i_alu_want && i_streak_max)) begin
      o_gnt[GNT_LSU] = 1'b1;
    end else if (i_alu_want) begin
      o_gnt[GNT_ALU] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_retire_arbiter.sv
// Arbitrates ALU/LSU completions onto the single ARF write port (1-cycle registered
// write); the loser sees ready low and holds, non-writing results retire at once.
module wb_retire_arbiter
  import riscv_uop_pkg::*;
#(
  parameter int MAX_LSU_STREAK = 3,
  parameter int CNT_W          = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_alu_valid,
  input  logic             i_alu_writes_rd,
  input  logic [4:0]       i_alu_rd,
  input  logic [31:0]      i_alu_data,
  output logic             o_alu_ready,
  input  logic             i_lsu_valid,
  input  logic             i_lsu_writes_rd,
  input  logic [4:0]       i_lsu_rd,
  input  logic [31:0]      i_lsu_data,
  output logic             o_lsu_ready,
  output logic             o_wb_en,
  output logic [4:0]       o_wb_rd,
  output logic [31:0]      o_wb_data,
  output logic             o_retire_fwd_writes_rd,
  output logic [4:0]       o_retire_fwd_rd,
  output logic [31:0]      o_retire_fwd_data,
  output logic [CNT_W-1:0] o_retired_cnt
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_LIMIT = SW'(MAX_LSU_STREAK);

  wb_req_t    alu_req, lsu_req;
  logic       alu_want, lsu_want;
  logic [1:0] gnt;

  logic [SW-1:0]    streak_d, streak_q;
  logic             wb_en_d, wb_en_q;
  logic [4:0]       wb_rd_d, wb_rd_q;
  logic [31:0]      wb_data_d, wb_data_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign alu_req  = '{valid: i_alu_valid, writes_rd: i_alu_writes_rd, rd: i_alu_rd, data: i_alu_data};
  assign lsu_req  = '{valid: i_lsu_valid, writes_rd: i_lsu_writes_rd, rd: i_lsu_rd, data: i_lsu_data};
  assign alu_want = wb_wants_port(alu_req);
  assign lsu_want = wb_wants_port(lsu_req);

  wb_prio_picker u_picker (
    .i_alu_want   (alu_want),
    .i_lsu_want   (lsu_want),
    .i_streak_max (streak_q == STREAK_LIMIT),
    .o_gnt        (gnt)
  );

  // Anything not competing for the port is accepted immediately.
  assign o_alu_ready = !alu_want || gnt[GNT_ALU];
  assign o_lsu_ready = !lsu_want || gnt[GNT_LSU];

  always_comb begin
    streak_d = streak_q;
    if (gnt[GNT_ALU]) begin
      streak_d = '0;
    end else if (gnt[GNT_LSU] && alu_want && (streak_q != STREAK_LIMIT)) begin
      streak_d = streak_q + 1'b1;
    end

    wb_en_d   = gnt[GNT_ALU] || gnt[GNT_LSU];
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (gnt[GNT_LSU]) begin
      wb_rd_d   = lsu_req.rd;
      wb_data_d = lsu_req.data;
    end else if (gnt[GNT_ALU]) begin
      wb_rd_d   = alu_req.rd;
      wb_data_d = alu_req.data;
    end

    cnt_d = cnt_q + CNT_W'(i_alu_valid && o_alu_ready) + CNT_W'(i_lsu_valid && o_lsu_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      streak_q  <= streak_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_wb_en                = wb_en_q;
  assign o_wb_rd                = wb_rd_q;
  assign o_wb_data              = wb_data_q;
  assign o_retire_fwd_writes_rd = wb_en_q;
  assign o_retire_fwd_rd        = wb_rd_q;
  assign o_retire_fwd_data      = wb_data_q;
  assign o_retired_cnt          = cnt_q;

endmodule

// File: tb/tb_wb_retire_arbiter.sv
// Directed vector bench for wb_retire_arbiter, plus reset and counter-wrap sequences.
module tb_wb_retire_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        alu_v, alu_w, lsu_v, lsu_w;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_d, lsu_d;
  logic        alu_rdy, lsu_rdy, wb_en, fwd_en;
  logic [4:0]  wb_rd, fwd_rd;
  logic [31:0] wb_data, fwd_data;
  logic [63:0] cnt;

  logic        b_alu_v, b_alu_w, b_lsu_v, b_lsu_w;
  logic [4:0]  b_alu_rd, b_lsu_rd;
  logic [31:0] b_alu_d, b_lsu_d;
  logic        b_alu_rdy, b_lsu_rdy, b_wb_en, b_fwd_en;
  logic [4:0]  b_wb_rd, b_fwd_rd;
  logic [31:0] b_wb_data, b_fwd_data;
  logic [3:0]  b_cnt;

  wb_retire_arbiter #(.MAX_LSU_STREAK(3), .CNT_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(alu_v), .i_alu_writes_rd(alu_w), .i_alu_rd(alu_rd), .i_alu_data(alu_d),
    .o_alu_ready(alu_rdy),
    .i_lsu_valid(lsu_v), .i_lsu_writes_rd(lsu_w), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_d),
    .o_lsu_ready(lsu_rdy),
    .o_wb_en(wb_en), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_retire_fwd_writes_rd(fwd_en), .o_retire_fwd_rd(fwd_rd), .o_retire_fwd_data(fwd_data),
    .o_retired_cnt(cnt)
  );

  wb_retire_arbiter #(.MAX_LSU_STREAK(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(b_alu_v), .i_alu_writes_rd(b_alu_w), .i_alu_rd(b_alu_rd), .i_alu_data(b_alu_d),
    .o_alu_ready(b_alu_rdy),
    .i_lsu_valid(b_lsu_v), .i_lsu_writes_rd(b_lsu_w), .i_lsu_rd(b_lsu_rd), .i_lsu_data(b_lsu_d),
    .o_lsu_ready(b_lsu_rdy),
    .o_wb_en(b_wb_en), .o_wb_rd(b_wb_rd), .o_wb_data(b_wb_data),
    .o_retire_fwd_writes_rd(b_fwd_en), .o_retire_fwd_rd(b_fwd_rd), .o_retire_fwd_data(b_fwd_data),
    .o_retired_cnt(b_cnt)
  );

  typedef struct {
    logic        av, aw;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv, lw;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_ardy, e_lrdy, e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic lw, input logic [4:0] lrd, input logic [31:0] ld);
    alu_v = av; alu_w = aw; alu_rd = ard; alu_d = ad;
    lsu_v = lv; lsu_w = lw; lsu_rd = lrd; lsu_d = ld;
  endtask

  task automatic contend();
    drive(1, 1, 5'd4, 32'h44, 1, 1, 5'd3, 32'h33);
  endtask

  initial begin
    // ALU-only write, then idle hold
    tbl.push_back('{1,1,5'd5,32'hDEADBEEF, 0,0,5'd0,32'h0,   1,1,1,5'd5,32'hDEADBEEF,64'd1});
    tbl.push_back('{0,0,5'd0,32'h0,        0,0,5'd0,32'h0,   1,1,0,5'd5,32'hDEADBEEF,64'd1});
    // Contention from streak 0: L,L,L,A,L
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        0,1,1,5'd3,32'h33,64'd2});
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        0,1,1,5'd3,32'h33,64'd3});
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        0,1,1,5'd3,32'h33,64'd4});
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        1,0,1,5'd4,32'h44,64'd5});
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        0,1,1,5'd3,32'h33,64'd6});
    // Store alongside ALU write: both retire, one write
    tbl.push_back('{1,1,5'd7,32'h77, 1,0,5'd0,32'h0,         1,1,1,5'd7,32'h77,64'd8});
    // Load to x0 alongside ALU write; then lone ALU write to x0
    tbl.push_back('{1,1,5'd9,32'h99, 1,1,5'd0,32'h5A,        1,1,1,5'd9,32'h99,64'd10});
    tbl.push_back('{1,1,5'd0,32'h11, 0,0,5'd0,32'h0,         1,1,0,5'd9,32'h99,64'd11});
    // Contention again: full L,L,L,A proves streak stayed at 0
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        0,1,1,5'd3,32'h33,64'd12});
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        0,1,1,5'd3,32'h33,64'd13});
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        0,1,1,5'd3,32'h33,64'd14});
    tbl.push_back('{1,1,5'd4,32'h44, 1,1,5'd3,32'h33,        1,0,1,5'd4,32'h44,64'd15});
    // Lone LSU load
    tbl.push_back('{0,0,5'd0,32'h0,  1,1,5'd12,32'hC0FFEE00, 1,1,1,5'd12,32'hC0FFEE00,64'd16});

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    b_alu_v = 0; b_alu_w = 0; b_alu_rd = 0; b_alu_d = 0;
    b_lsu_v = 0; b_lsu_w = 0; b_lsu_rd = 0; b_lsu_d = 0;
    repeat (2) @(negedge clk);
    chk("reset_wb_en", 64'(wb_en), 64'd0);
    chk("reset_wb_rd", 64'(wb_rd), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    chk("reset_cnt", cnt, 64'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].aw, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lw, tbl[i].lrd, tbl[i].ld);
      #1;
      chk($sformatf("v%0d_alu_rdy", i), 64'(alu_rdy), 64'(tbl[i].e_ardy));
      chk($sformatf("v%0d_lsu_rdy", i), 64'(lsu_rdy), 64'(tbl[i].e_lrdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wb_en", i), 64'(wb_en), 64'(tbl[i].e_en));
      chk($sformatf("v%0d_wb_rd", i), 64'(wb_rd), 64'(tbl[i].e_rd));
      chk($sformatf("v%0d_wb_data", i), 64'(wb_data), 64'(tbl[i].e_data));
      chk($sformatf("v%0d_fwd_en", i), 64'(fwd_en), 64'(tbl[i].e_en));
      chk($sformatf("v%0d_fwd_rd", i), 64'(fwd_rd), 64'(tbl[i].e_rd));
      chk($sformatf("v%0d_fwd_data", i), 64'(fwd_data), 64'(tbl[i].e_data));
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].e_cnt);
    end

    // Reset mid-operation: two LSU wins leave streak at 2 with a write in flight
    @(negedge clk);
    contend();
    repeat (2) @(negedge clk);
    chk("pre_rst_wb_en", 64'(wb_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wb_en", 64'(wb_en), 64'd0);
    chk("rst_async_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_async_wb_data", 64'(wb_data), 64'd0);
    chk("rst_async_cnt", cnt, 64'd0);
    chk("rst_lsu_rdy", 64'(lsu_rdy), 64'd1);
    chk("rst_alu_rdy", 64'(alu_rdy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("post_rst_c%0d_alu_rdy", c), 64'(alu_rdy), (c == 3) ? 64'd1 : 64'd0);
      chk($sformatf("post_rst_c%0d_lsu_rdy", c), 64'(lsu_rdy), (c == 3) ? 64'd0 : 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_c%0d_wb_rd", c), 64'(wb_rd), (c == 3) ? 64'd4 : 64'd3);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // 4-bit counter: 7 double accepts + 1 single reaches 15, then one more wraps
    b_alu_v = 1; b_alu_w = 1; b_alu_rd = 5'd1; b_alu_d = 32'h1;
    b_lsu_v = 1; b_lsu_w = 0;
    repeat (7) @(negedge clk);
    b_lsu_v = 0;
    @(negedge clk);
    chk("wrap_pre", 64'(b_cnt), 64'd15);
    @(negedge clk);
    chk("wrap_zero", 64'(b_cnt), 64'd0);
    b_alu_v = 0;

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
